// File: rtl/avalon_pwm_leds.sv
// Avalon-MM LED/GPIO port: atomic set/clear/toggle, per-channel static/PWM mode, shared prescaler.
// Zero-wait combinational reads; out_port is registered one cycle after the register update; never stalls.
module avalon_pwm_leds #(
  parameter int NUM_CH     = 9,
  parameter int PWM_BITS   = 8,
  parameter int PRESC_BITS = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] out_port
);

  logic [NUM_CH-1:0]     r_data;
  logic [NUM_CH-1:0]     r_mode;
  logic [PRESC_BITS-1:0] r_presc;
  logic [PRESC_BITS-1:0] r_pre_cnt;
  logic [PWM_BITS-1:0]   r_pwm_cnt;
  logic [PWM_BITS-1:0]   r_duty_shadow [NUM_CH];
  logic [PWM_BITS-1:0]   r_duty_active [NUM_CH];

  logic              w_wr;
  logic              w_presc_wr;
  logic              w_tick;
  logic              w_wrap;
  logic [NUM_CH-1:0] w_wd_ch;
  logic [NUM_CH-1:0] w_out_nxt;
  logic              w_unused;

  assign w_wr       = chipselect & ~write_n;
  assign w_presc_wr = w_wr && (address == 5'd5);
  assign w_wd_ch    = writedata[NUM_CH-1:0];
  assign w_unused   = ^writedata;

  // A prescaler write takes priority over a coincident tick: no increment, no wrap.
  assign w_tick = (r_pre_cnt == r_presc) && !w_presc_wr;
  assign w_wrap = w_tick && (&r_pwm_cnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_mode  <= '0;
      r_presc <= '0;
    end else if (w_wr) begin
      case (address)
        5'd0:    r_data  <= w_wd_ch;
        5'd1:    r_data  <= r_data | w_wd_ch;
        5'd2:    r_data  <= r_data & ~w_wd_ch;
        5'd3:    r_data  <= r_data ^ w_wd_ch;
        5'd4:    r_mode  <= w_wd_ch;
        5'd5:    r_presc <= writedata[PRESC_BITS-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
    end else if (w_presc_wr) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
    end else if (w_tick) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end else begin
      r_pre_cnt <= r_pre_cnt + 1'b1;
    end
  end

  // Active duty only moves at the period boundary (or freely while static), so a period is never cut short.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_duty_shadow[i] <= '0;
        r_duty_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr && (address == 5'(16 + i)))
          r_duty_shadow[i] <= writedata[PWM_BITS-1:0];
        if (w_wrap || !r_mode[i])
          r_duty_active[i] <= r_duty_shadow[i];
      end
    end
  end

  always_comb begin
    w_out_nxt = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_out_nxt[i] = r_data[i] & (!r_mode[i] | (r_pwm_cnt < r_duty_active[i]));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      out_port <= '0;
    else
      out_port <= w_out_nxt;
  end

  always_comb begin
    readdata = '0;
    case (address)
      5'd0:    readdata = 32'(r_data);
      5'd4:    readdata = 32'(r_mode);
      5'd5:    readdata = 32'(r_presc);
      default: begin
        for (int i = 0; i < NUM_CH; i++)
          if (address == 5'(16 + i))
            readdata = 32'(r_duty_shadow[i]);
      end
    endcase
  end

endmodule

// File: tb/tb_avalon_pwm_leds.sv
// Directed bench for avalon_pwm_leds: register access, atomic ops, PWM timing, prescaler and duty update.
module tb_avalon_pwm_leds;
  localparam int NUM_CH = 9;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [4:0]        address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] out_port;

  int total = 0;
  int bad   = 0;

  avalon_pwm_leds #(.NUM_CH(NUM_CH), .PWM_BITS(8), .PRESC_BITS(16)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  // High count of channel 0 over n clocks, plus clocks where channels 8:1 differ from 'up'.
  task automatic count_hi(input int n, input logic [7:0] up, output int hi, output int oth);
    hi = 0; oth = 0;
    repeat (n) begin
      @(negedge clk);
      if (out_port[0]) hi++;
      if (out_port[8:1] !== up) oth++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int hi, oth, hi2, n;
    logic [8:0] exp_data;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // 1: asynchronous reset clears the outputs and all registers
    wr(5'd0, 32'h1FF);
    @(negedge clk);
    chk("pre_reset_out", 32'(out_port), 32'h1FF);
    wr(5'd4, 32'h1); wr(5'd5, 32'h7); wr(5'd16, 32'h33);
    @(negedge clk);
    reset_n = 1'b0;
    #1 chk("async_reset_out", 32'(out_port), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(5'd0, d);  chk("rst_data", d, 32'h0);
    rd(5'd4, d);  chk("rst_mode", d, 32'h0);
    rd(5'd5, d);  chk("rst_presc", d, 32'h0);
    rd(5'd16, d); chk("rst_duty0", d, 32'h0);

    // 2: atomic set/clear/toggle
    exp_data = ((9'h0F0 | 9'h003) & ~9'h010) ^ 9'h101;
    wr(5'd0, 32'h0F0); wr(5'd1, 32'h003); wr(5'd2, 32'h010); wr(5'd3, 32'h101);
    chk("out_one_cycle_late", 32'(out_port), 32'h0E3);
    @(negedge clk);
    chk("out_after_tog", 32'(out_port), 32'(exp_data));
    rd(5'd0, d); chk("data_after_ops", d, 32'(exp_data));
    rd(5'd1, d); chk("set_reads_zero", d, 32'h0);
    rd(5'd6, d); chk("unmapped_reads_zero", d, 32'h0);

    // 3: PWM at prescale 0, channel 8 static high alongside
    wr(5'd5, 32'h0); wr(5'd16, 32'd64); wr(5'd4, 32'h001); wr(5'd0, 32'h101);
    repeat (300) @(negedge clk);
    count_hi(256, 8'h80, hi, oth);
    chk("pwm_duty64_high", 32'(hi), 32'd64);
    chk("pwm_static_others", 32'(oth), 32'd0);

    // 4: prescale 3 stretches the period to 1024 clocks
    wr(5'd5, 32'd3); wr(5'd16, 32'd128);
    repeat (1200) @(negedge clk);
    count_hi(1024, 8'h80, hi, oth);
    chk("presc3_high", 32'(hi), 32'd512);
    n = 0;
    while (out_port[0] !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    while (out_port[0] !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    chk("presc_find_low_phase", 32'(n < 2000), 32'd1);
    repeat (10) @(negedge clk);
    wr(5'd5, 32'd3);
    chk("presc_restart_before", 32'(out_port[0]), 32'd0);
    n = 0;
    @(negedge clk);
    while (out_port[0] === 1'b1 && n < 2000) begin n++; @(negedge clk); end
    chk("presc_restart_high_run", 32'(n), 32'd512);
    n = 0;
    while (out_port[0] === 1'b0 && n < 2000) begin n++; @(negedge clk); end
    chk("presc_restart_low_run", 32'(n), 32'd512);

    // 5: mid-period duty change only lands at the next wrap
    wr(5'd5, 32'd0); wr(5'd16, 32'd200);
    repeat (300) @(negedge clk);
    wr(5'd5, 32'd0);
    fork
      begin
        logic [31:0] rb;
        repeat (48) @(negedge clk);
        wr(5'd16, 32'd10);
        rd(5'd16, rb);
        chk("duty_readback_immediate", rb, 32'd10);
      end
      begin
        count_hi(256, 8'h80, hi, oth);
        count_hi(256, 8'h80, hi2, oth);
      end
    join
    chk("duty_current_period", 32'(hi), 32'd200);
    chk("duty_next_period", 32'(hi2), 32'd10);

    // 6: boundaries
    wr(5'd16, 32'd0);
    repeat (300) @(negedge clk);
    count_hi(256, 8'h80, hi, oth);
    chk("duty0_never_high", 32'(hi), 32'd0);
    wr(5'd16, 32'h1FF);
    repeat (300) @(negedge clk);
    count_hi(256, 8'h80, hi, oth);
    chk("duty255_high", 32'(hi), 32'd255);
    wr(5'd31, 32'hFFFF_FFFF);
    wr(5'd25, 32'hFFFF_FFFF);
    rd(5'd31, d); chk("addr31_reads_zero", d, 32'h0);
    rd(5'd25, d); chk("addr25_reads_zero", d, 32'h0);
    rd(5'd16, d); chk("duty0_kept", d, 32'd255);
    rd(5'd0, d);  chk("data_kept", d, 32'h101);
    rd(5'd4, d);  chk("mode_kept", d, 32'h001);
    rd(5'd5, d);  chk("presc_kept", d, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
